// File: rtl/bcd_entry_pkg.sv
// bcd_entry_pkg: shared key codes, entry states and digit width for the BCD operand entry block
package bcd_entry_pkg;
  localparam int DW = 4;
  localparam logic [DW-1:0] KEY_PLUS  = 4'd10;
  localparam logic [DW-1:0] KEY_MINUS = 4'd11;
  localparam logic [DW-1:0] KEY_ENTER = 4'd12;
  localparam logic [DW-1:0] KEY_CLEAR = 4'd13;
  typedef enum logic [1:0] {
    ST_OP1  = 2'd0,
    ST_OP2  = 2'd1,
    ST_DONE = 2'd2
  } state_t;
endpackage

// File: rtl/key_holdoff_timer.sv
// key_holdoff_timer: debounce guard, ready only once the down-counter has drained to zero
module key_holdoff_timer #(
  parameter int HOLDOFF_CYCLES = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  output logic ready
);
  logic [3:0] cnt_q, cnt_d;
  // reload on every accepted key, otherwise count down and stop at zero
  always_comb cnt_d = load ? 4'(HOLDOFF_CYCLES) : (cnt_q != 4'd0 ? cnt_q - 4'd1 : cnt_q);
  // counter register
  always_ff @(posedge clk or posedge rst)
    if (rst) cnt_q <= '0;
    else cnt_q <= cnt_d;
  assign ready = (cnt_q == 4'd0);
endmodule

// File: rtl/bcd_operand_entry.sv
// bcd_operand_entry: keyed entry of two 2-digit BCD operands and an operator; AUTO_SUBMIT_EN finishes on the second operand-2 digit
module bcd_operand_entry
  import bcd_entry_pkg::*;
#(
  parameter int HOLDOFF_CYCLES = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          key_valid,
  input  logic [DW-1:0] key_code,
  output logic          key_ready,
  output logic [DW-1:0] op1_10,
  output logic [DW-1:0] op1_1,
  output logic [DW-1:0] op2_10,
  output logic [DW-1:0] op2_1,
  output logic          operator,
  output logic          operands_valid,
  output logic [1:0]    entry_state,
  output logic          digit_err
);
  state_t        st_q, st_d;
  logic [DW-1:0] op1_10_q, op1_10_d, op1_1_q, op1_1_d, op2_10_q, op2_10_d, op2_1_q, op2_1_d;
  logic [1:0]    cnt1_q, cnt1_d, cnt2_q, cnt2_d;
  logic          oper_q, oper_d, err_q, err_d;
  logic          acc, is_dig, is_pm;
  assign acc    = key_valid & key_ready;
  assign is_dig = key_code < 4'd10;
  assign is_pm  = (key_code == KEY_PLUS) || (key_code == KEY_MINUS);
  key_holdoff_timer #(.HOLDOFF_CYCLES(HOLDOFF_CYCLES)) u_holdoff (
    .clk  (clk),
    .rst  (rst),
    .load (acc),
    .ready(key_ready)
  );
  // next entry state: clear/recovery first, then per-state key handling
  always_comb begin
    st_d     = st_q;
    op1_10_d = op1_10_q;
    op1_1_d  = op1_1_q;
    op2_10_d = op2_10_q;
    op2_1_d  = op2_1_q;
    cnt1_d   = cnt1_q;
    cnt2_d   = cnt2_q;
    oper_d   = oper_q;
    err_d    = 1'b0;
    if (!(st_q inside {ST_OP1, ST_OP2, ST_DONE}) || (acc && key_code == KEY_CLEAR)) begin
      st_d     = ST_OP1;
      op1_10_d = '0;
      op1_1_d  = '0;
      op2_10_d = '0;
      op2_1_d  = '0;
      cnt1_d   = '0;
      cnt2_d   = '0;
      oper_d   = 1'b0;
    end else if (acc) begin
      case (st_q)
        ST_OP1:
          if (is_dig) begin
            if (cnt1_q < 2'd2) begin
              op1_10_d = op1_1_q;
              op1_1_d  = key_code;
              cnt1_d   = cnt1_q + 2'd1;
            end else err_d = 1'b1;
          end else if (is_pm) begin
            oper_d = (key_code == KEY_MINUS);
            st_d   = ST_OP2;
          end
        ST_OP2:
          if (is_dig) begin
            if (cnt2_q < 2'd2) begin
              op2_10_d = op2_1_q;
              op2_1_d  = key_code;
              cnt2_d   = cnt2_q + 2'd1;
`ifdef AUTO_SUBMIT_EN
              if (cnt2_q == 2'd1) st_d = ST_DONE;
`endif
            end else err_d = 1'b1;
          end else if (is_pm) begin
            if (cnt2_q == 2'd0) oper_d = (key_code == KEY_MINUS);
          end else if (key_code == KEY_ENTER) st_d = ST_DONE;
        ST_DONE:
          if (is_dig) begin
            st_d     = ST_OP1;
            op1_10_d = '0;
            op1_1_d  = key_code;
            cnt1_d   = 2'd1;
            op2_10_d = '0;
            op2_1_d  = '0;
            cnt2_d   = '0;
            oper_d   = 1'b0;
          end
        default: ;
      endcase
    end
  end
  // entry state and operand registers
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      st_q     <= ST_OP1;
      op1_10_q <= '0;
      op1_1_q  <= '0;
      op2_10_q <= '0;
      op2_1_q  <= '0;
      cnt1_q   <= '0;
      cnt2_q   <= '0;
      oper_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      st_q     <= st_d;
      op1_10_q <= op1_10_d;
      op1_1_q  <= op1_1_d;
      op2_10_q <= op2_10_d;
      op2_1_q  <= op2_1_d;
      cnt1_q   <= cnt1_d;
      cnt2_q   <= cnt2_d;
      oper_q   <= oper_d;
      err_q    <= err_d;
    end
  assign op1_10         = op1_10_q;
  assign op1_1          = op1_1_q;
  assign op2_10         = op2_10_q;
  assign op2_1          = op2_1_q;
  assign operator       = oper_q;
  assign operands_valid = (st_q == ST_DONE);
  assign entry_state    = st_q;
  assign digit_err      = err_q;
endmodule

// File: tb/tb_bcd_operand_entry.sv
// tb_bcd_operand_entry: scoreboard bench for bcd_operand_entry, directed key sequences
module tb_bcd_operand_entry;
  logic       clk = 1'b0, rst = 1'b1, key_valid = 1'b0;
  logic [3:0] key_code = '0;
  logic       key_ready, operator, operands_valid, digit_err;
  logic [3:0] op1_10, op1_1, op2_10, op2_1;
  logic [1:0] entry_state;
  int         total = 0, bad = 0, cyc = 0;
  logic       acc_seen = 1'b0;
  logic [20:0] exp_q[$];
  string       name_q[$];
  int          acc_t[$];
  wire [20:0] act = {entry_state, op1_10, op1_1, op2_10, op2_1, operator, operands_valid, digit_err};

  always #5 clk = ~clk;

  bcd_operand_entry #(.HOLDOFF_CYCLES(4)) dut (
    .clk(clk), .rst(rst), .key_valid(key_valid), .key_code(key_code), .key_ready(key_ready),
    .op1_10(op1_10), .op1_1(op1_1), .op2_10(op2_10), .op2_1(op2_1), .operator(operator),
    .operands_valid(operands_valid), .entry_state(entry_state), .digit_err(digit_err)
  );

  function automatic logic [20:0] e(input logic [1:0] st, input logic [3:0] a, b, c, d,
                                    input logic op, input logic err);
    return {st, a, b, c, d, op, st == 2'd2, err};
  endfunction

  task automatic chk(input string n, input logic [20:0] a, input logic [20:0] x);
    total++;
    if (a !== x) begin
      bad++;
      $display("FAIL %s got=%h want=%h", n, a, x);
    end
  endtask

  always @(posedge clk) begin
    cyc      <= cyc + 1;
    acc_seen <= key_valid && key_ready;
  end

  // monitor: one expected snapshot per accepted key, checked the cycle after acceptance
  always @(negedge clk)
    if (acc_seen) begin
      acc_t.push_back(cyc);
      chk("ready_low_after_accept", {20'd0, key_ready}, 21'd0);
      if (exp_q.size() == 0) chk("unexpected_accept", 21'd1, 21'd0);
      else chk(name_q.pop_front(), act, exp_q.pop_front());
    end

  task automatic press(input logic [3:0] k, input logic [20:0] x, input string n);
    bit got = 0;
    @(negedge clk);
    exp_q.push_back(x);
    name_q.push_back(n);
    key_valid = 1'b1;
    key_code  = k;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      got = acc_seen;
    end
    key_valid = 1'b0;
    if (!got) begin
      chk({n, "_timeout"}, 21'd1, 21'd0);
      void'(exp_q.pop_back());
      void'(name_q.pop_back());
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=hang want=finish");
    $fatal(1);
  end

  initial begin
    int n;
    #1;
    chk("reset_async_outputs", act, 21'd0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("reset_outputs", act, 21'd0);
    chk("reset_ready", {20'd0, key_ready}, 21'd1);
    // 47 + 25 enter
    press(4'd4, e(0, 0, 4, 0, 0, 0, 0), "k4");
    press(4'd7, e(0, 4, 7, 0, 0, 0, 0), "k7");
    press(4'd10, e(1, 4, 7, 0, 0, 0, 0), "plus");
    press(4'd2, e(1, 4, 7, 0, 2, 0, 0), "k2");
`ifdef AUTO_SUBMIT_EN
    press(4'd5, e(2, 4, 7, 2, 5, 0, 0), "k5_auto");
`else
    press(4'd5, e(1, 4, 7, 2, 5, 0, 0), "k5");
`endif
    press(4'd12, e(2, 4, 7, 2, 5, 0, 0), "enter");
    press(4'd11, e(2, 4, 7, 2, 5, 0, 0), "minus_in_done");
    // digit overflow in OP1
    press(4'd13, 21'd0, "clear1");
    press(4'd1, e(0, 0, 1, 0, 0, 0, 0), "d1");
    press(4'd2, e(0, 1, 2, 0, 0, 0, 0), "d2");
    press(4'd3, e(0, 1, 2, 0, 0, 0, 1), "d3_err");
    @(negedge clk);
    chk("err_one_cycle", {20'd0, digit_err}, 21'd0);
    // operator replacement in OP2
    press(4'd13, 21'd0, "clear2");
    press(4'd11, e(1, 0, 0, 0, 0, 1, 0), "op_minus");
    press(4'd10, e(1, 0, 0, 0, 0, 0, 0), "op_plus_replace");
    press(4'd9, e(1, 0, 0, 0, 9, 0, 0), "k9");
    press(4'd11, e(1, 0, 0, 0, 9, 0, 0), "minus_ignored");
    press(4'd12, e(2, 0, 0, 0, 9, 0, 0), "enter2");
    // digit from DONE restarts, then reset mid-holdoff
    press(4'd8, e(0, 0, 8, 0, 0, 0, 0), "done_k8");
    #2 rst = 1'b1;
    #1;
    chk("rst_mid_holdoff", act, 21'd0);
    chk("rst_ready", {20'd0, key_ready}, 21'd1);
    @(negedge clk);
    rst = 1'b0;
    press(4'd14, 21'd0, "noop");
    press(4'd12, 21'd0, "enter_in_op1");
    // key_valid held: acceptances 5 cycles apart
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back(i == 0 ? e(0, 0, 5, 0, 0, 0, 0) : e(0, 5, 5, 0, 0, 0, i == 2));
      name_q.push_back($sformatf("hold5_%0d", i));
    end
    acc_t.delete();
    key_valid = 1'b1;
    key_code  = 4'd5;
    n = 0;
    for (int i = 0; i < 60 && n < 3; i++) begin
      @(negedge clk);
      if (acc_seen) n++;
    end
    key_valid = 1'b0;
    #1;
    chk("hold_count", 21'(n), 21'd3);
    if (acc_t.size() == 3) begin
      chk("spacing_a", 21'(acc_t[1] - acc_t[0]), 21'd5);
      chk("spacing_b", 21'(acc_t[2] - acc_t[1]), 21'd5);
    end else chk("hold_times", 21'(acc_t.size()), 21'd3);
    // optional auto-submit
    press(4'd13, 21'd0, "clear3");
    press(4'd3, e(0, 0, 3, 0, 0, 0, 0), "a3");
    press(4'd10, e(1, 0, 3, 0, 0, 0, 0), "aplus");
    press(4'd6, e(1, 0, 3, 0, 6, 0, 0), "a6");
`ifdef AUTO_SUBMIT_EN
    press(4'd1, e(2, 0, 3, 6, 1, 0, 0), "a1_auto");
    press(4'd12, e(2, 0, 3, 6, 1, 0, 0), "enter_in_done");
`else
    press(4'd1, e(1, 0, 3, 6, 1, 0, 0), "a1");
    press(4'd4, e(1, 0, 3, 6, 1, 0, 1), "op2_err");
`endif
    repeat (2) @(negedge clk);
    chk("queue_empty", 21'(exp_q.size()), 21'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/bcd_operand_entry.md
Name: bcd_operand_entry

Overview:
- Sequential front end for the 2-digit BCD add/subtract datapath; replaces raw switch operands with keyed entry.
- Accepts one key code per valid/ready handshake and assembles operand 1 (tens, ones), the operator and operand 2 (tens, ones).
- Presents the assembled operands and operator as stable registered outputs to the downstream BCD add/subtract and display logic.

Parameters:
- HOLDOFF_CYCLES, 4, cycles key_ready stays low after each accepted key (debounce guard); legal range 1..15.

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous, active-high reset
- key_valid  input  1  key_code is presented this cycle
- key_code  input  4  0-9 digit; 10 plus; 11 minus; 12 enter; 13 clear; 14-15 no-op
- key_ready  output  1  block can accept a key this cycle
- op1_10  output  4  operand 1 tens digit (BCD)
- op1_1  output  4  operand 1 ones digit
- op2_10  output  4  operand 2 tens digit
- op2_1  output  4  operand 2 ones digit
- operator  output  1  0 = add, 1 = subtract
- operands_valid  output  1  high while in DONE
- entry_state  output  2  current state encoding, for LED display
- digit_err  output  1  one-cycle pulse when a digit is rejected

Behaviour:
- Clock and reset: one clock (clk). Reset is asynchronous and active-high (rst).
- Reset values:
  - state = OP1
  - all digit outputs = 0; operator = 0
  - operands_valid = 0; digit_err = 0
  - digit counters = 0; holdoff counter = 0, so key_ready = 1
- Acceptance: a key is accepted on a rising edge where key_valid & key_ready. All outputs are registered, so effects appear the cycle after acceptance.
- Holdoff:
  - Every accepted key, including a no-op, loads the counter with HOLDOFF_CYCLES.
  - key_ready = (counter == 0). The counter decrements to 0.
  - Back-to-back accepted keys are therefore HOLDOFF_CYCLES+1 cycles apart.
- States (entry_state encoding): OP1 = 0, OP2 = 1, DONE = 2. Encoding 3 is unused; if reached, recover to OP1 with all values cleared.
- Digit key in OP1 or OP2 (cnt < 2):
  - Shift-in: tens <= ones, ones <= key_code; cnt++.
- Digit key in OP1 or OP2 (cnt == 2):
  - Operands unchanged; digit_err pulses for 1 cycle.
- Plus/minus key:
  - In OP1: operator <= (key_code == 11); go to OP2. Operand 1 may have 0 digits entered; it then holds value 00.
  - In OP2 with cnt2 == 0: replace operator.
  - In OP2 with cnt2 > 0: ignored.
  - In DONE: ignored.
- Enter key:
  - In OP2: go to DONE (cnt2 == 0 means operand 2 = 00); operands_valid <= 1.
  - In OP1 or DONE: ignored.
- Clear key: from any state, go to OP1 and clear all digits, operator and counters.
- Digit key in DONE:
  - Clear operand 2, operator and counters.
  - Operand 1 becomes 0,key_code; cnt1 = 1; go to OP1.
  - operands_valid drops the next cycle.
- Simultaneous events: a key arriving while key_ready = 0 is not accepted. The source must hold key_valid until it sees ready.
- Reset mid-entry or mid-holdoff: immediate return to the reset values listed above.
- Digits are never range-checked beyond the 0-9 code space; codes ≥ 10 are never shifted into operands.

Optional Feature:
- Macro: AUTO_SUBMIT_EN.
- Defined: in OP2, accepting the second digit (cnt2 becomes 2) also moves to DONE and sets operands_valid in the same update. An enter key is then unnecessary. An enter key in DONE stays ignored.
- Undefined: DONE is reached only by the enter key.

Decomposition:
- Shared package bcd_entry_pkg:
  - key code constants (KEY_PLUS = 10, KEY_MINUS = 11, KEY_ENTER = 12, KEY_CLEAR = 13)
  - state enum (OP1, OP2, DONE)
  - digit width constant 4
- One sub-module, key_holdoff_timer:
  - Inputs: clk, rst, load.
  - Output: ready.
  - Contains the 4-bit down-counter parameterised by HOLDOFF_CYCLES.

Test Plan:
- Reset, then keys 4, 7, plus, 2, 5, enter at HOLDOFF_CYCLES = 4 → op1 = 4,7; op2 = 2,5; operator = 0; operands_valid = 1; entry_state = 2.
- Keys 1, 2, 3 in OP1 → op1 = 1,2; digit_err pulses once on the third digit.
- Keys minus, plus, 9, minus, enter → operator = 0 (the second press replaced it; the minus after the digit is ignored); op1 = 0,0; op2 = 0,9.
- key_valid held high continuously with code 5 → successive acceptances exactly 5 cycles apart. key_ready low for 4 cycles after each.
- From DONE, key 8 → entry_state = 0; op1 = 0,8; op2 = 0,0; operands_valid = 0. Then rst asserted mid-holdoff → all outputs at reset values asynchronously.
- With AUTO_SUBMIT_EN: keys 3, plus, 6, 1 → DONE with operands_valid = 1 without an enter key.
